// File: rtl/traffic_phase_ctrl_if.sv
// rtl/traffic_phase_ctrl_if.sv - watch-side inputs and lamp/display outputs of the phase sequencer
interface traffic_phase_ctrl_if;
   logic       sec_tick;
   logic       day_or_night;
   logic       ped_req;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic       ped_walk;
   logic [2:0] phase;
   logic [7:0] remain;

   modport master (
      output sec_tick, day_or_night, ped_req,
      input  ns_light, ew_light, ped_walk, phase, remain
   );

   modport slave (
      input  sec_tick, day_or_night, ped_req,
      output ns_light, ew_light, ped_walk, phase, remain
   );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - NS/EW phase sequencer with night flash; TRAFFIC_PED_EN adds the pedestrian walk phase
// All outputs are registered from the next-state values so they change on the edge that samples sec_tick.
module traffic_phase_ctrl #(
   parameter int T_GREEN  = 10,
   parameter int T_YELLOW = 3,
   parameter int T_RED    = 2,
   parameter int T_PED    = 8
) (
   input logic                 clk,
   input logic                 rst,
   traffic_phase_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      NS_GREEN    = 3'd0,
      NS_YELLOW   = 3'd1,
      ALL_RED_1   = 3'd2,
      EW_GREEN    = 3'd3,
      EW_YELLOW   = 3'd4,
      ALL_RED_2   = 3'd5,
      PED_WALK    = 3'd6,
      NIGHT_FLASH = 3'd7
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] remain_q, remain_d;
   logic       flash_q, flash_d;
   logic [2:0] ns_q, ns_d;
   logic [2:0] ew_q, ew_d;
   logic       walk_q, walk_d;

`ifdef TRAFFIC_PED_EN
   logic       ped_pend_q, ped_pend_d;
`else
   logic       unused_ped_req;
   assign unused_ped_req = bus.ped_req;
`endif

   function automatic logic [7:0] dur_of(input state_e s);
      case (s)
         NS_GREEN, EW_GREEN:   dur_of = T_GREEN[7:0];
         NS_YELLOW, EW_YELLOW: dur_of = T_YELLOW[7:0];
         ALL_RED_1, ALL_RED_2: dur_of = T_RED[7:0];
         PED_WALK:             dur_of = T_PED[7:0];
         default:              dur_of = 8'd0;
      endcase
   endfunction

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      flash_d  = flash_q;
      if (bus.sec_tick) begin
         if (state_q == NIGHT_FLASH) begin
            if (!bus.day_or_night) begin
               state_d  = ALL_RED_2;
               remain_d = T_RED[7:0];
               flash_d  = 1'b0;
            end else begin
               flash_d  = ~flash_q;
            end
         end else if (remain_q != 8'd1) begin
            remain_d = remain_q - 8'd1;
         end else begin
            case (state_q)
               NS_GREEN:  state_d = NS_YELLOW;
               NS_YELLOW: state_d = ALL_RED_1;
               ALL_RED_1: state_d = bus.day_or_night ? NIGHT_FLASH : EW_GREEN;
               EW_GREEN:  state_d = EW_YELLOW;
               EW_YELLOW: state_d = ALL_RED_2;
               ALL_RED_2: begin
                  if (bus.day_or_night)
                     state_d = NIGHT_FLASH;
`ifdef TRAFFIC_PED_EN
                  else if (ped_pend_q)
                     state_d = PED_WALK;
`endif
                  else
                     state_d = NS_GREEN;
               end
               default:   state_d = NS_GREEN;
            endcase
            remain_d = dur_of(state_d);
            // Lamps come on immediately when night flashing begins.
            flash_d  = (state_d == NIGHT_FLASH);
         end
      end
   end

`ifdef TRAFFIC_PED_EN
   always_comb begin
      ped_pend_d = ped_pend_q;
      if (state_d == PED_WALK && state_q != PED_WALK)
         ped_pend_d = 1'b0;
      if (bus.ped_req)
         ped_pend_d = 1'b1;
   end
`endif

   always_comb begin
      ns_d   = 3'b100;
      ew_d   = 3'b100;
      walk_d = 1'b0;
      case (state_d)
         NS_GREEN:    ns_d = 3'b001;
         NS_YELLOW:   ns_d = 3'b010;
         EW_GREEN:    ew_d = 3'b001;
         EW_YELLOW:   ew_d = 3'b010;
         NIGHT_FLASH: begin
            ns_d = {1'b0, flash_d, 1'b0};
            ew_d = {flash_d, 2'b00};
         end
`ifdef TRAFFIC_PED_EN
         PED_WALK:    walk_d = 1'b1;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ALL_RED_2;
         remain_q <= T_RED[7:0];
         flash_q  <= 1'b0;
         ns_q     <= 3'b100;
         ew_q     <= 3'b100;
         walk_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         flash_q  <= flash_d;
         ns_q     <= ns_d;
         ew_q     <= ew_d;
         walk_q   <= walk_d;
      end
   end

`ifdef TRAFFIC_PED_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         ped_pend_q <= 1'b0;
      else
         ped_pend_q <= ped_pend_d;
   end
`endif

   assign bus.phase    = state_q;
   assign bus.remain   = remain_q;
   assign bus.ns_light = ns_q;
   assign bus.ew_light = ew_q;
   assign bus.ped_walk = walk_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - vector table, corner sequences and random run against a schedule model
module tb_traffic_phase_ctrl;

`ifdef TRAFFIC_PED_EN
   localparam bit PED_EN = 1'b1;
`else
   localparam bit PED_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   traffic_phase_ctrl_if bus();

   traffic_phase_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int         n;
      bit         dn;
      logic [2:0] ph;
      logic [7:0] rem;
      logic [2:0] ns;
      logic [2:0] ew;
   } vec_t;

   vec_t tbl[$];

   int n_chk  = 0;
   int n_pass = 0;

   // Model: phase plus ticks elapsed in it; remain is derived as duration minus elapsed.
   int         dur_tab[8] = '{10, 3, 2, 10, 3, 2, 8, 0};
   logic [2:0] ns_tab[8]  = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000};
   logic [2:0] ew_tab[8]  = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b000};
   int m_phase;
   int m_elapsed;
   bit m_flash;
   bit m_pend;

   localparam logic [17:0] RESET_VEC = {3'd5, 8'd2, 3'b100, 3'b100, 1'b0};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   function automatic logic [17:0] obs();
      return {bus.phase, bus.remain, bus.ns_light, bus.ew_light, bus.ped_walk};
   endfunction

   function automatic logic [17:0] exp_vec();
      logic [2:0] ns, ew;
      logic [7:0] rem;
      if (m_phase == 7) begin
         ns  = {1'b0, m_flash, 1'b0};
         ew  = {m_flash, 2'b00};
         rem = 8'd0;
      end else begin
         ns  = ns_tab[m_phase];
         ew  = ew_tab[m_phase];
         rem = 8'(dur_tab[m_phase] - m_elapsed);
      end
      return {3'(m_phase), rem, ns, ew, (m_phase == 6)};
   endfunction

   task automatic model_reset();
      m_phase = 5; m_elapsed = 0; m_flash = 1'b0; m_pend = 1'b0;
   endtask

   task automatic model_step(input bit t, input bit dn, input bit rq);
      bit enter_walk;
      enter_walk = 1'b0;
      if (t) begin
         if (m_phase == 7) begin
            if (!dn) begin m_phase = 5; m_elapsed = 0; m_flash = 1'b0; end
            else m_flash = !m_flash;
         end else begin
            m_elapsed++;
            if (m_elapsed == dur_tab[m_phase]) begin
               m_elapsed = 0;
               case (m_phase)
                  2:       m_phase = dn ? 7 : 3;
                  5:       m_phase = dn ? 7 : ((PED_EN && m_pend) ? 6 : 0);
                  6:       m_phase = 0;
                  default: m_phase = m_phase + 1;
               endcase
               if (m_phase == 7) m_flash = 1'b1;
               if (m_phase == 6) enter_walk = 1'b1;
            end
         end
      end
      if (PED_EN) begin
         if (enter_walk) m_pend = 1'b0;
         if (rq) m_pend = 1'b1;
      end
   endtask

   task automatic cycle(input bit t, input bit dn, input bit rq);
      @(negedge clk);
      bus.sec_tick = t; bus.day_or_night = dn; bus.ped_req = rq;
      @(posedge clk);
      model_step(t, dn, rq);
      #1;
      chk("model", 32'(obs()), 32'(exp_vec()));
   endtask

   task automatic ticks(input int n, input bit dn);
      for (int i = 0; i < n; i++) begin
         cycle(1'b1, dn, 1'b0);
         cycle(1'b0, dn, 1'b0);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; bus.sec_tick = 1'b0; bus.day_or_night = 1'b0; bus.ped_req = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_vals", 32'(obs()), 32'(RESET_VEC));
      rst = 1'b1;
   endtask

   initial begin
      bus.sec_tick = 1'b0; bus.day_or_night = 1'b0; bus.ped_req = 1'b0;
      model_reset();

      tbl.push_back(vec_t'{0,  1'b0, 3'd5, 8'd2,  3'b100, 3'b100});
      tbl.push_back(vec_t'{1,  1'b0, 3'd5, 8'd1,  3'b100, 3'b100});
      tbl.push_back(vec_t'{1,  1'b0, 3'd0, 8'd10, 3'b001, 3'b100});
      tbl.push_back(vec_t'{9,  1'b0, 3'd0, 8'd1,  3'b001, 3'b100});
      tbl.push_back(vec_t'{1,  1'b0, 3'd1, 8'd3,  3'b010, 3'b100});
      tbl.push_back(vec_t'{3,  1'b0, 3'd2, 8'd2,  3'b100, 3'b100});
      tbl.push_back(vec_t'{2,  1'b0, 3'd3, 8'd10, 3'b100, 3'b001});
      tbl.push_back(vec_t'{10, 1'b0, 3'd4, 8'd3,  3'b100, 3'b010});
      tbl.push_back(vec_t'{3,  1'b0, 3'd5, 8'd2,  3'b100, 3'b100});
      tbl.push_back(vec_t'{2,  1'b0, 3'd0, 8'd10, 3'b001, 3'b100});
      tbl.push_back(vec_t'{10, 1'b0, 3'd1, 8'd3,  3'b010, 3'b100});
      tbl.push_back(vec_t'{3,  1'b0, 3'd2, 8'd2,  3'b100, 3'b100});
      tbl.push_back(vec_t'{2,  1'b0, 3'd3, 8'd10, 3'b100, 3'b001});
      tbl.push_back(vec_t'{1,  1'b1, 3'd3, 8'd9,  3'b100, 3'b001});
      tbl.push_back(vec_t'{9,  1'b1, 3'd4, 8'd3,  3'b100, 3'b010});
      tbl.push_back(vec_t'{3,  1'b1, 3'd5, 8'd2,  3'b100, 3'b100});
      tbl.push_back(vec_t'{1,  1'b1, 3'd5, 8'd1,  3'b100, 3'b100});
      tbl.push_back(vec_t'{1,  1'b1, 3'd7, 8'd0,  3'b010, 3'b100});
      tbl.push_back(vec_t'{1,  1'b1, 3'd7, 8'd0,  3'b000, 3'b000});
      tbl.push_back(vec_t'{1,  1'b1, 3'd7, 8'd0,  3'b010, 3'b100});
      tbl.push_back(vec_t'{1,  1'b0, 3'd5, 8'd2,  3'b100, 3'b100});
      tbl.push_back(vec_t'{2,  1'b0, 3'd0, 8'd10, 3'b001, 3'b100});
      tbl.push_back(vec_t'{10, 1'b0, 3'd1, 8'd3,  3'b010, 3'b100});
      tbl.push_back(vec_t'{3,  1'b0, 3'd2, 8'd2,  3'b100, 3'b100});
      tbl.push_back(vec_t'{1,  1'b1, 3'd2, 8'd1,  3'b100, 3'b100});
      tbl.push_back(vec_t'{1,  1'b1, 3'd7, 8'd0,  3'b010, 3'b100});
      tbl.push_back(vec_t'{1,  1'b0, 3'd5, 8'd2,  3'b100, 3'b100});

      do_reset();
      foreach (tbl[i]) begin
         ticks(tbl[i].n, tbl[i].dn);
         chk($sformatf("vec%0d", i), 32'({bus.phase, bus.remain, bus.ns_light, bus.ew_light}),
             32'({tbl[i].ph, tbl[i].rem, tbl[i].ns, tbl[i].ew}));
      end

      // Pedestrian request during NS_GREEN, served after ALL_RED_2 only when compiled in.
      ticks(2, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      ticks(28, 1'b0);
      chk("ped_before", 32'({bus.phase, bus.remain}), 32'({3'd5, 8'd2}));
      ticks(2, 1'b0);
      if (PED_EN) chk("ped_enter", 32'({bus.phase, bus.remain, bus.ped_walk}), 32'({3'd6, 8'd8, 1'b1}));
      else        chk("ped_enter", 32'({bus.phase, bus.remain, bus.ped_walk}), 32'({3'd0, 8'd10, 1'b0}));
      ticks(8, 1'b0);
      if (PED_EN) chk("ped_exit", 32'({bus.phase, bus.remain, bus.ped_walk}), 32'({3'd0, 8'd10, 1'b0}));
      else        chk("ped_exit", 32'({bus.phase, bus.remain, bus.ped_walk}), 32'({3'd0, 8'd2, 1'b0}));

      // Asynchronous reset in EW_YELLOW with a pending request that must be discarded.
      do_reset();
      ticks(2, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      ticks(26, 1'b0);
      chk("ew_yellow_rem2", 32'({bus.phase, bus.remain}), 32'({3'd4, 8'd2}));
      @(posedge clk);
      #3 rst = 1'b0;
      #1 chk("async_reset", 32'(obs()), 32'(RESET_VEC));
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      ticks(2, 1'b0);
      chk("pend_cleared", 32'({bus.phase, bus.remain, bus.ped_walk}), 32'({3'd0, 8'd10, 1'b0}));

      // Random run including back-to-back ticks and mid-phase input changes.
      begin
         bit dn;
         dn = 1'b1;
         for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) dn = !dn;
            cycle(($urandom_range(0, 2) == 0), dn, ($urandom_range(0, 39) == 0));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
